// File: rtl/event_unit_pkg.sv
// Shared definitions for the interrupt vector arbiter.
// Holds the arbiter state encoding, the APB register offsets (PADDR[3:2])
// and the bit positions of the CUR_ID status register.
package event_unit_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } state_e;

   localparam logic [1:0] REG_MODE   = 2'd0;
   localparam logic [1:0] REG_ENABLE = 2'd1;
   localparam logic [1:0] REG_CUR_ID = 2'd2;

   localparam int CUR_ID_REQ_BIT = 31;
   localparam int CUR_ID_TO_BIT  = 30;

endpackage

// File: rtl/rr_find_first.sv
// Combinational find-first-set with wrap.
// The search begins at ptr_i+1 and wraps modulo N, so the line at ptr_i
// itself is examined last. Passing ptr_i = N-1 gives plain lowest-index-first.
// Ports:
//   req_i   - request vector
//   ptr_i   - index of the most recent winner
//   found_o - at least one bit of req_i is set
//   idx_o   - index of the first set bit found
module rr_find_first #(
   parameter int N = 32,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] req_i,
   input  logic [W-1:0] ptr_i,
   output logic         found_o,
   output logic [W-1:0] idx_o
);

   // Walk the search order backwards so the nearest candidate is written last.
   always_comb begin
      int c;
      c       = 0;
      found_o = 1'b0;
      idx_o   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         c = (int'(ptr_i) + 1 + i) % N;
         if (req_i[W'(c)]) begin
            found_o = 1'b1;
            idx_o   = W'(c);
         end
      end
   end

endmodule

// File: rtl/irq_vector_arbiter.sv
// Interrupt vector arbiter: picks one pending, enabled line, presents its ID
// to the core with a req/ack handshake and pulses a one-hot clear back to the
// interrupt service unit after the ack.
// Optional build macro IRQ_ARB_TIMEOUT_EN adds an ack timeout and a sticky
// timeout flag in CUR_ID bit30.
// Ports:
//   HCLK, HRESETn          - clock, async active-low reset
//   PADDR..PSLVERR         - APB slave (MODE, ENABLE, CUR_ID registers)
//   irq_pending_i          - level pending vector
//   irq_req_o, irq_id_o    - request and line ID to the core
//   irq_ack_i              - core acknowledge
//   irq_clear_o            - one-cycle one-hot clear for the acked line
//
// state | meaning
// IDLE  | no request outstanding; arbitrating every cycle
// REQ   | irq_req_o high, ID latched; waiting for ack, withdrawal (or timeout)
module irq_vector_arbiter
   import event_unit_pkg::*;
#(
   parameter  int APB_ADDR_WIDTH = 12,
   parameter  int NUM_IRQ        = 32,
   parameter  int TIMEOUT_CYCLES = 256,
   localparam int IDW            = $clog2(NUM_IRQ)
) (
   input  logic                      HCLK,
   input  logic                      HRESETn,
   input  logic [APB_ADDR_WIDTH-1:0] PADDR,
   input  logic [31:0]               PWDATA,
   input  logic                      PWRITE,
   input  logic                      PSEL,
   input  logic                      PENABLE,
   output logic [31:0]               PRDATA,
   output logic                      PREADY,
   output logic                      PSLVERR,
   input  logic [NUM_IRQ-1:0]        irq_pending_i,
   output logic                      irq_req_o,
   output logic [IDW-1:0]            irq_id_o,
   input  logic                      irq_ack_i,
   output logic [NUM_IRQ-1:0]        irq_clear_o
);

   logic               r_mode;
   logic [NUM_IRQ-1:0] r_enable;
   state_e             r_state;
   logic               r_req;
   logic [IDW-1:0]     r_id;
   logic [IDW-1:0]     r_rr_ptr;
   logic [NUM_IRQ-1:0] r_clear;

   logic [1:0]         w_reg;
   logic               w_wr;
   logic [NUM_IRQ-1:0] w_eligible;
   logic [IDW-1:0]     w_ptr;
   logic               w_found;
   logic [IDW-1:0]     w_idx;
   logic               w_to_expired;
   logic               w_to_flag;
   logic               w_unused;

   assign w_reg      = PADDR[3:2];
   assign w_wr       = PSEL & PENABLE & PWRITE;
   assign w_eligible = irq_pending_i & r_enable;
   // Fixed priority is the round-robin search started just past the top line.
   assign w_ptr      = r_mode ? r_rr_ptr : IDW'(NUM_IRQ - 1);

   // Undecoded address/data bits and the timeout length in the default build.
   assign w_unused = ^{PADDR, PWDATA, 16'(TIMEOUT_CYCLES)};

   rr_find_first #(.N(NUM_IRQ), .W(IDW)) u_find (
      .req_i   (w_eligible),
      .ptr_i   (w_ptr),
      .found_o (w_found),
      .idx_o   (w_idx)
   );

`ifdef IRQ_ARB_TIMEOUT_EN
   logic [15:0] r_to_cnt;
   logic        r_to_flag;
   assign w_to_expired = (r_to_cnt == '0);
   assign w_to_flag    = r_to_flag;
`else
   assign w_to_expired = 1'b0;
   assign w_to_flag    = 1'b0;
`endif

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_mode   <= 1'b0;
         r_enable <= '1;
      end else if (w_wr) begin
         case (w_reg)
            REG_MODE:   r_mode   <= PWDATA[0];
            REG_ENABLE: r_enable <= PWDATA[NUM_IRQ-1:0];
            default:    ;
         endcase
      end
   end

   always_comb begin
      PRDATA = '0;
      if (PSEL && !PWRITE) begin
         case (w_reg)
            REG_MODE:   PRDATA[0] = r_mode;
            REG_ENABLE: PRDATA[NUM_IRQ-1:0] = r_enable;
            REG_CUR_ID: begin
               PRDATA[CUR_ID_REQ_BIT] = r_req;
               PRDATA[CUR_ID_TO_BIT]  = w_to_flag;
               PRDATA[IDW-1:0]        = r_id;
            end
            default:    ;
         endcase
      end
   end

   assign PREADY  = 1'b1;
   assign PSLVERR = PSEL & PENABLE & (w_reg == 2'd3);

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_state  <= IDLE;
         r_req    <= 1'b0;
         r_id     <= '0;
         r_rr_ptr <= IDW'(NUM_IRQ - 1);
         r_clear  <= '0;
`ifdef IRQ_ARB_TIMEOUT_EN
         r_to_cnt  <= '0;
         r_to_flag <= 1'b0;
`endif
      end else begin
         r_clear <= '0;
`ifdef IRQ_ARB_TIMEOUT_EN
         // A timeout in the same cycle as the clear write keeps the flag set.
         if (w_wr && (w_reg == REG_CUR_ID) && PWDATA[CUR_ID_TO_BIT])
            r_to_flag <= 1'b0;
`endif
         case (r_state)
            IDLE: begin
               if (w_found) begin
                  r_state <= REQ;
                  r_req   <= 1'b1;
                  r_id    <= w_idx;
`ifdef IRQ_ARB_TIMEOUT_EN
                  r_to_cnt <= 16'(TIMEOUT_CYCLES - 1);
`endif
               end
            end
            REQ: begin
               // Ack takes precedence over a simultaneous withdrawal.
               if (irq_ack_i) begin
                  r_state  <= IDLE;
                  r_req    <= 1'b0;
                  r_rr_ptr <= r_id;
                  r_clear  <= NUM_IRQ'(1) << r_id;
               end else if (!w_eligible[r_id]) begin
                  r_state <= IDLE;
                  r_req   <= 1'b0;
               end else if (w_to_expired) begin
                  // Moving the pointer onto the stuck line demotes it in round-robin.
                  r_state  <= IDLE;
                  r_req    <= 1'b0;
                  r_rr_ptr <= r_id;
`ifdef IRQ_ARB_TIMEOUT_EN
                  r_to_flag <= 1'b1;
               end else begin
                  r_to_cnt <= r_to_cnt - 16'd1;
`endif
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign irq_req_o   = r_req;
   assign irq_id_o    = r_id;
   assign irq_clear_o = r_clear;

endmodule

// File: tb/tb_irq_vector_arbiter.sv
module tb_irq_vector_arbiter;

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic [11:0] PADDR;
   logic [31:0] PWDATA;
   logic        PWRITE;
   logic        PSEL;
   logic        PENABLE;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;
   logic [31:0] irq_pending_i;
   logic        irq_req_o;
   logic [4:0]  irq_id_o;
   logic        irq_ack_i;
   logic [31:0] irq_clear_o;

   always #5 HCLK = ~HCLK;

   irq_vector_arbiter #(
      .APB_ADDR_WIDTH (12),
      .NUM_IRQ        (32),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .HCLK          (HCLK),
      .HRESETn       (HRESETn),
      .PADDR         (PADDR),
      .PWDATA        (PWDATA),
      .PWRITE        (PWRITE),
      .PSEL          (PSEL),
      .PENABLE       (PENABLE),
      .PRDATA        (PRDATA),
      .PREADY        (PREADY),
      .PSLVERR       (PSLVERR),
      .irq_pending_i (irq_pending_i),
      .irq_req_o     (irq_req_o),
      .irq_id_o      (irq_id_o),
      .irq_ack_i     (irq_ack_i),
      .irq_clear_o   (irq_clear_o)
   );

   typedef struct {
      logic [31:0] pend;
      logic        ack;
      logic        exp_req;
      logic [4:0]  exp_id;
      logic [31:0] exp_clr;
   } vec_t;

   vec_t tbl[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic void add(input logic [31:0] pend, input logic ack, input logic req,
                               input logic [4:0] id, input logic [31:0] clr);
      vec_t v;
      v.pend    = pend;
      v.ack     = ack;
      v.exp_req = req;
      v.exp_id  = id;
      v.exp_clr = clr;
      tbl.push_back(v);
   endfunction

   task automatic step(input logic [31:0] pend, input logic ack);
      @(negedge HCLK);
      irq_pending_i = pend;
      irq_ack_i     = ack;
      @(posedge HCLK);
      #1;
   endtask

   task automatic check_out(input string name, input logic req, input logic [4:0] id,
                            input logic [31:0] clr);
      check({name, "_req"}, 32'(irq_req_o), 32'(req));
      check({name, "_clr"}, irq_clear_o, clr);
      if (req) check({name, "_id"}, 32'(irq_id_o), 32'(id));
   endtask

   task automatic run_table(input string name);
      foreach (tbl[i]) begin
         step(tbl[i].pend, tbl[i].ack);
         check_out($sformatf("%s[%0d]", name, i), tbl[i].exp_req, tbl[i].exp_id, tbl[i].exp_clr);
      end
      tbl.delete();
   endtask

   task automatic apb_write(input logic [11:0] addr, input logic [31:0] data);
      @(negedge HCLK);
      irq_ack_i = 1'b0;
      PSEL      = 1'b1;
      PENABLE   = 1'b0;
      PWRITE    = 1'b1;
      PADDR     = addr;
      PWDATA    = data;
      @(negedge HCLK);
      PENABLE = 1'b1;
      @(negedge HCLK);
      PSEL    = 1'b0;
      PENABLE = 1'b0;
      PWRITE  = 1'b0;
   endtask

   task automatic apb_read_check(input string name, input logic [11:0] addr,
                                 input logic [31:0] exp_data, input logic exp_err);
      @(negedge HCLK);
      irq_ack_i = 1'b0;
      PSEL      = 1'b1;
      PENABLE   = 1'b0;
      PWRITE    = 1'b0;
      PADDR     = addr;
      @(negedge HCLK);
      PENABLE = 1'b1;
      #1;
      check({name, "_data"}, PRDATA, exp_data);
      check({name, "_err"}, 32'(PSLVERR), 32'(exp_err));
      @(negedge HCLK);
      PSEL    = 1'b0;
      PENABLE = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge HCLK);
      HRESETn       = 1'b0;
      irq_pending_i = '0;
      irq_ack_i     = 1'b0;
      PSEL          = 1'b0;
      PENABLE       = 1'b0;
      PWRITE        = 1'b0;
      @(negedge HCLK);
      @(negedge HCLK);
      HRESETn = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      HRESETn       = 1'b0;
      PADDR         = '0;
      PWDATA        = '0;
      PWRITE        = 1'b0;
      PSEL          = 1'b0;
      PENABLE       = 1'b0;
      irq_pending_i = '0;
      irq_ack_i     = 1'b0;
      repeat (2) @(negedge HCLK);
      HRESETn = 1'b1;
      #1;
      check("rst_req", 32'(irq_req_o), 32'd0);
      check("rst_id", 32'(irq_id_o), 32'd0);
      check("rst_clr", irq_clear_o, 32'd0);
      check("rst_prdata", PRDATA, 32'd0);
      check("rst_pslverr", 32'(PSLVERR), 32'd0);
      check("rst_pready", 32'(PREADY), 32'd1);
      apb_read_check("rst_mode", 12'h000, 32'h0000_0000, 1'b0);
      apb_read_check("rst_enable", 12'h004, 32'hFFFF_FFFF, 1'b0);
      apb_read_check("rst_cur_id", 12'h008, 32'h0000_0000, 1'b0);

      // Fixed priority: lowest eligible wins, including the top line alone.
      add(32'h0000_0014, 1'b0, 1'b1, 5'd2,  32'h0);
      add(32'h0000_0014, 1'b1, 1'b0, 5'd0,  32'h0000_0004);
      add(32'h0000_0000, 1'b0, 1'b0, 5'd0,  32'h0);
      add(32'h8000_0000, 1'b0, 1'b1, 5'd31, 32'h0);
      add(32'h8000_0000, 1'b1, 1'b0, 5'd0,  32'h8000_0000);
      add(32'h0000_0000, 1'b0, 1'b0, 5'd0,  32'h0);
      run_table("fixed");

      // Round-robin with a grant/ack on every opportunity.
      do_reset();
      apb_write(12'h000, 32'h1);
      apb_read_check("rr_mode", 12'h000, 32'h0000_0001, 1'b0);
      add(32'h8000_0003, 1'b0, 1'b1, 5'd0,  32'h0);
      add(32'h8000_0003, 1'b1, 1'b0, 5'd0,  32'h0000_0001);
      add(32'h8000_0003, 1'b0, 1'b1, 5'd1,  32'h0);
      add(32'h8000_0003, 1'b1, 1'b0, 5'd0,  32'h0000_0002);
      add(32'h8000_0003, 1'b0, 1'b1, 5'd31, 32'h0);
      add(32'h8000_0003, 1'b1, 1'b0, 5'd0,  32'h8000_0000);
      add(32'h8000_0003, 1'b0, 1'b1, 5'd0,  32'h0);
      add(32'h8000_0003, 1'b1, 1'b0, 5'd0,  32'h0000_0001);
      add(32'h8000_0003, 1'b0, 1'b1, 5'd1,  32'h0);
      add(32'h8000_0003, 1'b1, 1'b0, 5'd0,  32'h0000_0002);
      add(32'h0000_0000, 1'b0, 1'b0, 5'd0,  32'h0);
      run_table("rr");

      // Withdrawal leaves rr_ptr at 31, so 0x300 must grant 8 rather than 9.
      do_reset();
      apb_write(12'h000, 32'h1);
      add(32'h0000_0100, 1'b0, 1'b1, 5'd8, 32'h0);
      add(32'h0000_0000, 1'b0, 1'b0, 5'd0, 32'h0);
      add(32'h0000_0300, 1'b0, 1'b1, 5'd8, 32'h0);
      add(32'h0000_0300, 1'b1, 1'b0, 5'd0, 32'h0000_0100);
      add(32'h0000_0000, 1'b0, 1'b0, 5'd0, 32'h0);
      run_table("withdraw");

      // Enable mask gating, CUR_ID readback and the invalid register.
      do_reset();
      apb_write(12'h004, 32'hFFFF_FFFE);
      add(32'h0000_0001, 1'b0, 1'b0, 5'd0, 32'h0);
      add(32'h0000_0001, 1'b0, 1'b0, 5'd0, 32'h0);
      run_table("masked");
      apb_write(12'h004, 32'hFFFF_FFFF);
      add(32'h0000_0001, 1'b0, 1'b1, 5'd0, 32'h0);
      run_table("unmasked");
      apb_read_check("cur_id_req", 12'h008, 32'h8000_0000, 1'b0);
      add(32'h0000_0001, 1'b1, 1'b0, 5'd0, 32'h0000_0001);
      add(32'h0000_0000, 1'b0, 1'b0, 5'd0, 32'h0);
      run_table("unmasked_ack");
      apb_read_check("invalid_rd", 12'h00C, 32'h0000_0000, 1'b1);
      apb_write(12'h00C, 32'hFFFF_FFFF);
      apb_read_check("invalid_wr_mode", 12'h000, 32'h0000_0000, 1'b0);

      // Ack and withdrawal together: the ack wins.
      do_reset();
      add(32'h0000_0020, 1'b0, 1'b1, 5'd5, 32'h0);
      add(32'h0000_0000, 1'b1, 1'b0, 5'd0, 32'h0000_0020);
      add(32'h0000_0000, 1'b0, 1'b0, 5'd0, 32'h0);
      run_table("ack_wd");

      // Reset asserted while a request is outstanding.
      do_reset();
      step(32'h0000_0020, 1'b0);
      check_out("pre_rst", 1'b1, 5'd5, 32'h0);
      @(negedge HCLK);
      HRESETn       = 1'b0;
      irq_pending_i = '0;
      irq_ack_i     = 1'b1;
      #1;
      check("mid_rst_req", 32'(irq_req_o), 32'd0);
      check("mid_rst_id", 32'(irq_id_o), 32'd0);
      check("mid_rst_clr", irq_clear_o, 32'd0);
      @(negedge HCLK);
      HRESETn   = 1'b1;
      irq_ack_i = 1'b0;
      @(posedge HCLK);
      #1;
      check_out("post_rst", 1'b0, 5'd0, 32'h0);

`ifdef IRQ_ARB_TIMEOUT_EN
      do_reset();
      apb_write(12'h000, 32'h1);
      step(32'h0000_0003, 1'b0);
      check_out("to_grant0", 1'b1, 5'd0, 32'h0);
      for (int k = 1; k < 16; k++) begin
         step(32'h0000_0003, 1'b0);
         check_out($sformatf("to_hold%0d", k), 1'b1, 5'd0, 32'h0);
      end
      step(32'h0000_0003, 1'b0);
      check_out("to_drop", 1'b0, 5'd0, 32'h0);
      step(32'h0000_0003, 1'b0);
      check_out("to_grant1", 1'b1, 5'd1, 32'h0);
      apb_read_check("to_flag_set", 12'h008, 32'hC000_0001, 1'b0);
      apb_write(12'h008, 32'h4000_0000);
      apb_read_check("to_flag_clr", 12'h008, 32'h8000_0001, 1'b0);
      step(32'h0000_0003, 1'b1);
      check_out("to_ack1", 1'b0, 5'd0, 32'h0000_0002);
      step(32'h0000_0000, 1'b0);
`else
      do_reset();
      step(32'h0000_0003, 1'b0);
      check_out("no_to_grant", 1'b1, 5'd0, 32'h0);
      repeat (40) step(32'h0000_0003, 1'b0);
      check_out("no_to_hold", 1'b1, 5'd0, 32'h0);
      apb_read_check("no_to_flag", 12'h008, 32'h8000_0000, 1'b0);
      step(32'h0000_0003, 1'b1);
      check_out("no_to_ack", 1'b0, 5'd0, 32'h0000_0001);
      step(32'h0000_0000, 1'b0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
